// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes used by the control decoder and the execute
// stage, plus the entry format held in the execute-stage result buffer.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SLT   = 5'b00101;
    localparam logic [4:0] ALU_SLTU  = 5'b00110;
    localparam logic [4:0] ALU_AUIPC = 5'b01000;
    localparam logic [4:0] ALU_LUI   = 5'b01001;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 zero;
        logic                 illegal;
    } alu_entry_t;

    // Idle/reset contents: a zero result with Zero set
    localparam alu_entry_t ALU_ENTRY_RESET = '{result: '0, zero: 1'b1, illegal: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes the 5-bit control code and produces result,
// Zero and Illegal. Undefined (or unknown) codes yield a zero result.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    // Op decode; X/Z codes match no item and fall to the illegal default
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_control)
            ALU_ADD,
            ALU_AUIPC: result = src_a + src_b;
            ALU_SUB:   result = src_a - src_b;
            ALU_AND:   result = src_a & src_b;
            ALU_OR:    result = src_a | src_b;
            ALU_XOR:   result = src_a ^ src_b;
            ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            ALU_LUI:   result = src_b;
            default:   illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: the ALU result is captured into a 2-entry
// (main + skid) buffer behind a valid/ready handshake, so the stage sustains
// one result per cycle and absorbs a single-cycle stall without bubbles.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    // Buffer entries use the shared package format, which fixes the width
    if (WIDTH != ALU_WIDTH) begin : g_width_check
        $error("alu_exec_stage: WIDTH must equal alu_pkg::ALU_WIDTH");
    end

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_illegal;
    alu_entry_t       core_entry;

    alu_entry_t main_q;
    alu_entry_t skid_q;
    logic       main_valid_q;
    logic       skid_valid_q;

    logic accept;
    logic pop;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .alu_control (ALUControl),
        .src_a       (SrcA),
        .src_b       (SrcB),
        .result      (core_result),
        .zero        (core_zero),
        .illegal     (core_illegal)
    );

    assign core_entry = '{result: core_result, zero: core_zero, illegal: core_illegal};

    // in_ready is purely registered: only a full skid slot blocks new input
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign pop      = main_valid_q & out_ready;

    // Main/skid buffer update; main always holds the oldest entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= ALU_ENTRY_RESET;
            skid_q       <= ALU_ENTRY_RESET;
        end else if (pop) begin
            if (skid_valid_q) begin
                // Skid full means in_ready was low, so no accept can coincide
                main_q       <= skid_q;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                main_q <= core_entry;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_q       <= core_entry;
                skid_valid_q <= 1'b1;
            end else begin
                main_q       <= core_entry;
                main_valid_q <= 1'b1;
            end
        end
    end

    assign out_valid = main_valid_q;
    assign ALUResult = main_q.result;
    assign Zero      = main_q.zero;
    assign Illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed + randomised self-checking bench for alu_exec_stage.
module tb_alu_exec_stage;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SLT   = 5'b00101;
    localparam logic [4:0] OP_SLTU  = 5'b00110;
    localparam logic [4:0] OP_AUIPC = 5'b01000;
    localparam logic [4:0] OP_LUI   = 5'b01001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  ALUControl = 5'b0;
    logic [31:0] SrcA = 32'h0;
    logic [31:0] SrcB = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_stage #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid   = v;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
    endtask

    // Reference: {illegal, zero, result}
    function automatic logic [33:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        r   = 32'h0;
        ill = 1'b0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            OP_AUIPC: r = a + b;
            OP_LUI:   r = b;
            default:  ill = 1'b1;
        endcase
        return {ill, (r == 32'h0), r};
    endfunction

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_checks++;
        if (ALUResult !== 32'h0) begin
            n_fail++; $display("FAIL reset_result got=%h exp=0", ALUResult);
        end
        n_checks++;
        if (Zero !== 1'b1 || Illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got Zero=%b Illegal=%b exp Zero=1 Illegal=0",
                               Zero, Illegal);
        end
        reset = 1'b0;
        // Fill both entries under backpressure, then reset mid-cycle
        drive(1'b1, OP_ADD, 32'd1, 32'd2);
        @(negedge clk);
        drive(1'b1, OP_ADD, 32'd3, 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || ALUResult !== 32'd3) begin
            n_fail++; $display("FAIL full_before_reset got in_ready=%b out_valid=%b res=%h exp 0 1 3",
                               in_ready, out_valid, ALUResult);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset_hs got out_valid=%b in_ready=%b exp 0 1",
                               out_valid, in_ready);
        end
        n_checks++;
        if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
            n_fail++; $display("FAIL async_reset_data got res=%h Zero=%b exp 0 1", ALUResult, Zero);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 32'd5, 32'd3);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'd8 || Zero !== 1'b0) begin
            n_fail++; $display("FAIL b2b_add got v=%b res=%h Z=%b exp 1 8 0", out_valid, ALUResult, Zero);
        end
        drive(1'b1, OP_SUB, 32'd5, 32'd3);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'd2) begin
            n_fail++; $display("FAIL b2b_sub got v=%b res=%h exp 1 2", out_valid, ALUResult);
        end
        drive(1'b1, OP_SLT, 32'd5, 32'd3);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
            n_fail++; $display("FAIL b2b_slt got v=%b res=%h Z=%b exp 1 0 1", out_valid, ALUResult, Zero);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_signed;
        out_ready = 1'b1;
        drive(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'd1) begin
            n_fail++; $display("FAIL slt_neg got=%h exp=1", ALUResult);
        end
        drive(1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
            n_fail++; $display("FAIL sltu_big got res=%h Z=%b exp 0 1", ALUResult, Zero);
        end
        drive(1'b1, OP_SUB, 32'd7, 32'd7);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1 || Illegal !== 1'b0) begin
            n_fail++; $display("FAIL sub_equal got res=%h Z=%b I=%b exp 0 1 0", ALUResult, Zero, Illegal);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 32'd10, 32'd20);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'd30 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first got v=%b res=%h rdy=%b exp 1 1e 1",
                               out_valid, ALUResult, in_ready);
        end
        drive(1'b1, OP_XOR, 32'h0000_00F0, 32'h0000_000F);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || ALUResult !== 32'd30) begin
            n_fail++; $display("FAIL bp_skid got rdy=%b res=%h exp 0 1e", in_ready, ALUResult);
        end
        // in_valid held high while not ready must be ignored
        drive(1'b1, OP_ADD, 32'd1, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || ALUResult !== 32'd30 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b res=%h rdy=%b exp 1 1e 0",
                                   i, out_valid, ALUResult, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'hFF || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second got v=%b res=%h rdy=%b exp 1 ff 1",
                               out_valid, ALUResult, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_extra got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_auipc_lui;
        out_ready = 1'b1;
        drive(1'b1, OP_AUIPC, 32'h0000_1000, 32'h0001_2000);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'h0001_3000) begin
            n_fail++; $display("FAIL auipc got=%h exp=00013000", ALUResult);
        end
        drive(1'b1, OP_LUI, 32'h5555_5555, 32'hABCD_E000);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'hABCD_E000 || Illegal !== 1'b0) begin
            n_fail++; $display("FAIL lui got res=%h I=%b exp abcde000 0", ALUResult, Illegal);
        end
        drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
            n_fail++; $display("FAIL add_wrap got res=%h Z=%b exp 0 1", ALUResult, Zero);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        drive(1'b1, 5'b10101, 32'd5, 32'd3);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'h0 || Illegal !== 1'b1 || Zero !== 1'b1) begin
            n_fail++; $display("FAIL illegal_10101 got res=%h I=%b Z=%b exp 0 1 1",
                               ALUResult, Illegal, Zero);
        end
        drive(1'b1, 5'b00111, 32'd9, 32'd1);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'h0 || Illegal !== 1'b1 || Zero !== 1'b1) begin
            n_fail++; $display("FAIL illegal_00111 got res=%h I=%b Z=%b exp 0 1 1",
                               ALUResult, Illegal, Zero);
        end
        // Zero operands make the result 0 whatever an unknown code resolves to
        drive(1'b1, 5'bxxxxx, 32'd0, 32'd0);
        @(negedge clk);
        n_checks++;
        if (ALUResult !== 32'h0 || Zero !== 1'b1 ||
            ^{ALUResult, Zero, Illegal, out_valid} === 1'bx) begin
            n_fail++; $display("FAIL illegal_x got res=%h Z=%b I=%b exp 0 1 no-x",
                               ALUResult, Zero, Illegal);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [4:0]  ops[10];
        logic [33:0] exp_q[$];
        logic [33:0] prev;
        logic [33:0] cur;
        logic        stalled;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_AUIPC, OP_LUI,
                5'b11111};
        stalled = 1'b0;
        prev    = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            cur = {Illegal, Zero, ALUResult};
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || cur !== prev) begin
                    n_fail++; $display("FAIL rnd_stable cyc=%0d got v=%b %h exp 1 %h",
                                       cyc, out_valid, cur, prev);
                end
            end
            n_checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b",
                                   cyc, out_valid, (exp_q.size() != 0));
            end
            out_ready = (cyc < 370) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                n_checks++;
                if (cur !== exp_q[0]) begin
                    n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, cur, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            stalled = out_valid && !out_ready;
            prev    = cur;
            op = ops[$urandom_range(0, 9)];
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom);
            if (cyc < 360 && $urandom_range(0, 2) != 0) begin
                drive(1'b1, op, a, b);
                if (in_ready) exp_q.push_back(model(op, a, b));
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rnd_drain got out_valid=%b pending=%0d exp 0 0",
                               out_valid, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_signed();
        test_backpressure();
        test_auipc_lui();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
